// File: rtl/esc_ramp_seq.sv
// ---------------------------------------------------------------------------
// esc_ramp_seq
//   Arm / ramp / hold sequencer for an ESC speed command. After enable the
//   speed term is held at zero for ARM_CYCLES cycles. It then moves toward
//   the loaded target by at most STEP every RAMP_DIV cycles, and holds once
//   the target is reached.
//
//   Optional feature macro: ESC_SOFT_STOP_EN
//     undefined : dropping en in RAMP/HOLD zeroes SPEED and returns to IDLE
//                 on the next edge.
//     defined   : dropping en in RAMP/HOLD ramps SPEED down to 0 first, then
//                 returns to IDLE. Raising en again before 0 resumes the ramp
//                 toward the loaded target without re-arming.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   en       in   1  run level (1 = run, 0 = stop)
//   load     in   1  one-cycle pulse, captures tgt_spd / tgt_off
//   tgt_spd  in  11  requested speed
//   tgt_off  in  10  requested offset
//   SPEED    out 11  registered speed term
//   OFF      out 10  registered offset term
//   state    out  2  IDLE=00 ARM=01 RAMP=10 HOLD=11 (debug / status)
//   armed    out  1  high from ARM completion until return to IDLE
//   at_tgt   out  1  high while in HOLD
//
// Handshake: load is a qualifier-free strobe. Every cycle it is high the
// target and offset registers take the new values, whatever the state.
// ---------------------------------------------------------------------------
module esc_ramp_seq #(
    parameter logic [15:0] ARM_CYCLES = 16'd50000,
    parameter logic [15:0] RAMP_DIV   = 16'd5000,
    parameter logic [10:0] STEP       = 11'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [10:0] tgt_spd,
    input  logic [9:0]  tgt_off,
    output logic [10:0] SPEED,
    output logic [9:0]  OFF,
    output logic [1:0]  state,
    output logic        armed,
    output logic        at_tgt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RAMP = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    state_t      r_state,   w_state_nx;
    logic [10:0] r_speed,   w_speed_nx;
    logic [10:0] r_tgt;
    logic [9:0]  r_off;
    logic [15:0] r_arm_cnt, w_arm_cnt_nx;
    logic [15:0] r_pre_cnt, w_pre_cnt_nx;
    logic        r_armed,   w_armed_nx;
    logic        r_stop,    w_stop_nx;

    logic        w_stop_active;
    logic        w_step_due;
    logic [10:0] w_target;
    logic [10:0] w_step_val;

    // The stop flag only steers the ramp while en is still low. When en
    // returns, the target switches straight back to the loaded value.
    // In the default build r_stop never leaves 0.
    assign w_stop_active = r_stop & ~en;
    assign w_target      = w_stop_active ? 11'd0 : r_tgt;
    assign w_step_due    = (r_pre_cnt == RAMP_DIV - 16'd1);

    // One ramp step. The move is clamped to the target, so it never
    // overshoots. Each branch only adds or subtracts STEP when the distance
    // to the target exceeds STEP, so the 11-bit value never wraps.
    always_comb begin
        w_step_val = w_target;
        if (r_speed < w_target) begin
            if ((w_target - r_speed) > STEP)
                w_step_val = r_speed + STEP;
        end else begin
            if ((r_speed - w_target) > STEP)
                w_step_val = r_speed - STEP;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_speed_nx   = r_speed;
        w_arm_cnt_nx = r_arm_cnt;
        w_pre_cnt_nx = r_pre_cnt;
        w_armed_nx   = r_armed;
        w_stop_nx    = r_stop;

        case (r_state)
            ST_IDLE: begin
                w_speed_nx = 11'd0;
                w_armed_nx = 1'b0;
                w_stop_nx  = 1'b0;
                if (en) begin
                    w_state_nx   = ST_ARM;
                    w_arm_cnt_nx = 16'd0;
                end
            end

            ST_ARM: begin
                if (!en) begin
                    w_state_nx   = ST_IDLE;
                    w_arm_cnt_nx = 16'd0;
                end else if (r_arm_cnt == ARM_CYCLES - 16'd1) begin
                    w_state_nx   = ST_RAMP;
                    w_armed_nx   = 1'b1;
                    w_pre_cnt_nx = 16'd0;
                end else begin
                    w_arm_cnt_nx = r_arm_cnt + 16'd1;
                end
            end

            default: begin // ST_RAMP, ST_HOLD
                if (!en && !r_stop) begin
`ifdef ESC_SOFT_STOP_EN
                    // Start the soft stop. No step is taken on this edge,
                    // and the step cadence restarts when coming from HOLD.
                    w_stop_nx  = 1'b1;
                    w_state_nx = ST_RAMP;
                    if (r_state == ST_HOLD || w_step_due)
                        w_pre_cnt_nx = 16'd0;
                    else
                        w_pre_cnt_nx = r_pre_cnt + 16'd1;
`else
                    w_state_nx = ST_IDLE;
                    w_speed_nx = 11'd0;
                    w_armed_nx = 1'b0;
`endif
                end else if (r_state == ST_HOLD) begin
                    if (load && (tgt_spd != r_speed)) begin
                        w_state_nx   = ST_RAMP;
                        w_pre_cnt_nx = 16'd0;
                    end
                end else begin
                    w_stop_nx = w_stop_active;
                    if (r_speed == w_target) begin
                        // Entered or continued RAMP with nothing left to do.
                        if (w_stop_active) begin
                            w_state_nx = ST_IDLE;
                            w_armed_nx = 1'b0;
                            w_stop_nx  = 1'b0;
                        end else begin
                            w_state_nx = ST_HOLD;
                        end
                    end else if (w_step_due) begin
                        w_speed_nx   = w_step_val;
                        w_pre_cnt_nx = 16'd0;
                        if (w_step_val == w_target) begin
                            if (w_stop_active) begin
                                w_state_nx = ST_IDLE;
                                w_armed_nx = 1'b0;
                                w_stop_nx  = 1'b0;
                            end else begin
                                w_state_nx = ST_HOLD;
                            end
                        end
                    end else begin
                        w_pre_cnt_nx = r_pre_cnt + 16'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_speed   <= 11'd0;
            r_tgt     <= 11'd0;
            r_off     <= 10'd0;
            r_arm_cnt <= 16'd0;
            r_pre_cnt <= 16'd0;
            r_armed   <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_speed   <= w_speed_nx;
            r_arm_cnt <= w_arm_cnt_nx;
            r_pre_cnt <= w_pre_cnt_nx;
            r_armed   <= w_armed_nx;
            r_stop    <= w_stop_nx;
            if (load) begin
                r_tgt <= tgt_spd;
                r_off <= tgt_off;
            end
        end
    end

    assign SPEED  = r_speed;
    assign OFF    = r_off;
    assign state  = r_state;
    assign armed  = r_armed;
    assign at_tgt = (r_state == ST_HOLD);

endmodule
